// File: rtl/fp_vector_seq.sv
// Test-vector sequencer: fetches stored vectors, issues them to fp_unit, checks result and flags.
// Build option: define FP_SEQ_CONTINUE_EN to check every vector instead of halting at the first mismatch.
module fp_vector_seq #(
  parameter int ADDR_W = 16,
  parameter int FP_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] vec_count,
  input  logic [2:0]        cfg_rm,
  input  logic              cfg_nan_chk,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [100:0]      vec_data,
  output logic              fp_enable,
  output logic [31:0]       fp_data1,
  output logic [31:0]       fp_data2,
  output logic [2:0]        fp_rm,
  input  logic [31:0]       fp_result,
  input  logic [4:0]        fp_flags,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_count,
  output logic [ADDR_W-1:0] fail_index,
  output logic [31:0]       fail_ref,
  output logic [31:0]       fail_calc,
  output logic [4:0]        fail_flags_ref,
  output logic [4:0]        fail_flags_calc
);

`ifdef FP_SEQ_CONTINUE_EN
  localparam bit CONTINUE_EN = 1'b1;
`else
  localparam bit CONTINUE_EN = 1'b0;
`endif

  localparam int CNT_W = (FP_LAT > 1) ? $clog2(FP_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (&v) ? v : v + ADDR_W'(1);
  endfunction

  // A canonical quiet NaN from the unit only has to agree with the reference on exponent and quiet bit.
  function automatic logic result_mismatch(input logic nan_chk, input logic [31:0] ref_v,
                                           input logic [31:0] calc_v);
    if (nan_chk && calc_v == 32'h7FC0_0000) return ref_v[30:22] != calc_v[30:22];
    return ref_v != calc_v;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              nan_chk_q, nan_chk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vec_rd_q, vec_rd_d;
  logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
  logic              fp_enable_q, fp_enable_d;
  logic [31:0]       fp_data1_q, fp_data1_d;
  logic [31:0]       fp_data2_q, fp_data2_d;
  logic [2:0]        fp_rm_q, fp_rm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] err_count_q, err_count_d;
  logic [ADDR_W-1:0] fail_index_q, fail_index_d;
  logic [31:0]       fail_ref_q, fail_ref_d;
  logic [31:0]       fail_calc_q, fail_calc_d;
  logic [4:0]        fail_flags_ref_q, fail_flags_ref_d;
  logic [4:0]        fail_flags_calc_q, fail_flags_calc_d;

  // Reference half of the fetched vector; pure data, never reset.
  logic [31:0]       ref_res_q;
  logic [4:0]        ref_flags_q;
  logic              load_vec;
  logic              mismatch;
  logic              last_vec;

  assign load_vec = (state_q == S_LOAD);
  assign mismatch = result_mismatch(nan_chk_q, ref_res_q, fp_result) || (ref_flags_q != fp_flags);
  assign last_vec = (index_q + ADDR_W'(1)) == count_q;

  always_comb begin
    state_d           = state_q;
    index_d           = index_q;
    count_d           = count_q;
    nan_chk_d         = nan_chk_q;
    cnt_d             = cnt_q;
    vec_rd_d          = 1'b0;
    vec_addr_d        = vec_addr_q;
    fp_enable_d       = 1'b0;
    fp_data1_d        = fp_data1_q;
    fp_data2_d        = fp_data2_q;
    fp_rm_d           = fp_rm_q;
    busy_d            = busy_q;
    done_d            = done_q;
    pass_d            = pass_q;
    err_count_d       = err_count_q;
    fail_index_d      = fail_index_q;
    fail_ref_d        = fail_ref_q;
    fail_calc_d       = fail_calc_q;
    fail_flags_ref_d  = fail_flags_ref_q;
    fail_flags_calc_d = fail_flags_calc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d           = vec_count;
          nan_chk_d         = cfg_nan_chk;
          fp_rm_d           = cfg_rm;
          index_d           = '0;
          err_count_d       = '0;
          fail_index_d      = '0;
          fail_ref_d        = '0;
          fail_calc_d       = '0;
          fail_flags_ref_d  = '0;
          fail_flags_calc_d = '0;
          if (vec_count == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d    = S_FETCH;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            vec_rd_d   = 1'b1;
            vec_addr_d = '0;
          end
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        fp_data1_d  = vec_data[31:0];
        fp_data2_d  = vec_data[63:32];
        fp_enable_d = 1'b1;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(FP_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CHECK: begin
        if (mismatch) begin
          err_count_d = sat_inc(err_count_q);
          if (err_count_q == '0) begin
            fail_index_d      = index_q;
            fail_ref_d        = ref_res_q;
            fail_calc_d       = fp_result;
            fail_flags_ref_d  = ref_flags_q;
            fail_flags_calc_d = fp_flags;
          end
        end
        if ((mismatch && !CONTINUE_EN) || last_vec) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == '0);
        end else begin
          index_d    = index_q + ADDR_W'(1);
          vec_addr_d = index_q + ADDR_W'(1);
          vec_rd_d   = 1'b1;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      index_q           <= '0;
      count_q           <= '0;
      nan_chk_q         <= 1'b0;
      cnt_q             <= '0;
      vec_rd_q          <= 1'b0;
      vec_addr_q        <= '0;
      fp_enable_q       <= 1'b0;
      fp_data1_q        <= '0;
      fp_data2_q        <= '0;
      fp_rm_q           <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      fail_index_q      <= '0;
      fail_ref_q        <= '0;
      fail_calc_q       <= '0;
      fail_flags_ref_q  <= '0;
      fail_flags_calc_q <= '0;
    end else begin
      state_q           <= state_d;
      index_q           <= index_d;
      count_q           <= count_d;
      nan_chk_q         <= nan_chk_d;
      cnt_q             <= cnt_d;
      vec_rd_q          <= vec_rd_d;
      vec_addr_q        <= vec_addr_d;
      fp_enable_q       <= fp_enable_d;
      fp_data1_q        <= fp_data1_d;
      fp_data2_q        <= fp_data2_d;
      fp_rm_q           <= fp_rm_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      fail_index_q      <= fail_index_d;
      fail_ref_q        <= fail_ref_d;
      fail_calc_q       <= fail_calc_d;
      fail_flags_ref_q  <= fail_flags_ref_d;
      fail_flags_calc_q <= fail_flags_calc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (load_vec) begin
      ref_res_q   <= vec_data[95:64];
      ref_flags_q <= vec_data[100:96];
    end
  end

  assign vec_rd          = vec_rd_q;
  assign vec_addr        = vec_addr_q;
  assign fp_enable       = fp_enable_q;
  assign fp_data1        = fp_data1_q;
  assign fp_data2        = fp_data2_q;
  assign fp_rm           = fp_rm_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign fail_index      = fail_index_q;
  assign fail_ref        = fail_ref_q;
  assign fail_calc       = fail_calc_q;
  assign fail_flags_ref  = fail_flags_ref_q;
  assign fail_flags_calc = fail_flags_calc_q;

endmodule

// File: tb/tb_fp_vector_seq.sv
// Bench for fp_vector_seq: vector memory and fp_unit models, issue log checked against an expectation queue.
module tb_fp_vector_seq;
  localparam int ADDR_W  = 16;
  localparam int FP_LAT  = 1;
  localparam int SPACING = 4 + FP_LAT;
`ifdef FP_SEQ_CONTINUE_EN
  localparam int FLAG_ISSUES = 4;
`else
  localparam int FLAG_ISSUES = 3;
`endif

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  rm;
  } issue_t;

  logic              clock = 1'b0;
  logic              reset, start, cfg_nan_chk;
  logic [ADDR_W-1:0] vec_count;
  logic [2:0]        cfg_rm;
  logic              vec_rd, fp_enable, busy, done, pass;
  logic [ADDR_W-1:0] vec_addr, err_count, fail_index;
  logic [100:0]      vec_data;
  logic [31:0]       fp_data1, fp_data2, fp_result, fail_ref, fail_calc;
  logic [2:0]        fp_rm;
  logic [4:0]        fp_flags, fail_flags_ref, fail_flags_calc;

  fp_vector_seq #(.ADDR_W(ADDR_W), .FP_LAT(FP_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .vec_count(vec_count), .cfg_rm(cfg_rm),
    .cfg_nan_chk(cfg_nan_chk), .vec_rd(vec_rd), .vec_addr(vec_addr), .vec_data(vec_data),
    .fp_enable(fp_enable), .fp_data1(fp_data1), .fp_data2(fp_data2), .fp_rm(fp_rm),
    .fp_result(fp_result), .fp_flags(fp_flags), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_index(fail_index), .fail_ref(fail_ref), .fail_calc(fail_calc),
    .fail_flags_ref(fail_flags_ref), .fail_flags_calc(fail_flags_calc)
  );

  always #5 clock = ~clock;

  logic [100:0] mem [16];
  logic [31:0]  calc_res [16];
  logic [4:0]   calc_flg [16];

  always @(posedge clock) if (vec_rd) vec_data <= mem[vec_addr[3:0]];

  // fp_unit stand-in: answer selected by the vector id carried in data1, held until the next issue.
  always @(posedge clock) begin
    if (fp_enable) begin
      fp_result <= calc_res[fp_data1[3:0]];
      fp_flags  <= calc_flg[fp_data1[3:0]];
    end
  end

  int     cyc = 0;
  int     n_issues = 0;
  issue_t obs [256];
  int     obs_cyc [256];
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (fp_enable === 1'b1) begin
      if (n_issues < 256) begin
        obs[n_issues]     <= '{fp_data1, fp_data2, fp_rm};
        obs_cyc[n_issues] <= cyc;
      end
      n_issues <= n_issues + 1;
    end
  end

  int     total = 0;
  int     bad = 0;
  issue_t exp_q [$];

  task automatic setvec(input int i, input logic [31:0] rr, input logic [4:0] rf,
                        input logic [31:0] cr, input logic [4:0] cf);
    mem[i]      = {rf, rr, $urandom(), 32'h1000_0000 | 32'(i)};
    calc_res[i] = cr;
    calc_flg[i] = cf;
  endtask

  task automatic push_exp(input int i, input logic [2:0] rm);
    exp_q.push_back('{mem[i][31:0], mem[i][63:32], rm});
  endtask

  task automatic start_run(input int cnt, input logic [2:0] rm, input logic nan);
    vec_count   = ADDR_W'(cnt);
    cfg_rm      = rm;
    cfg_nan_chk = nan;
    start       = 1'b1;
    @(negedge clock);
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (done !== 1'b1) begin
      total++; bad++;
      $display("FAIL %s timeout done=%b want 1", name, done);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; vec_count = '0; cfg_rm = '0; cfg_nan_chk = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if ({busy, done, pass, vec_rd, fp_enable} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {busy, done, pass, vec_rd, fp_enable});
    end
    total++;
    if ({err_count, fail_index, vec_addr} !== '0) begin
      bad++; $display("FAIL reset_counts got=%h want=0", {err_count, fail_index, vec_addr});
    end
    total++;
    if ({fp_data1, fp_data2, fp_rm} !== '0) begin
      bad++; $display("FAIL reset_operands got=%h want=0", {fp_data1, fp_data2, fp_rm});
    end
    total++;
    if ({fail_ref, fail_calc, fail_flags_ref, fail_flags_calc} !== '0) begin
      bad++; $display("FAIL reset_fail got=%h want=0", {fail_ref, fail_calc, fail_flags_ref, fail_flags_calc});
    end
  endtask

  task automatic test_zero_count();
    int base = n_issues;
    start_run(0, 3'd0, 1'b0);
    total++;
    if ({done, pass, busy} !== 3'b110 || err_count !== '0) begin
      bad++; $display("FAIL zero_count done/pass/busy=%b err=%0d want 110 err=0", {done, pass, busy}, err_count);
    end
    repeat (6) @(negedge clock);
    #1;
    total++;
    if (n_issues != base) begin
      bad++; $display("FAIL zero_count issues got=%0d want=0", n_issues - base);
    end
  endtask

  task automatic test_three_pass();
    int base = n_issues;
    int n_exp;
    issue_t e;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] r = $urandom();
      setvec(i, r, 5'(i), r, 5'(i));
      push_exp(i, 3'b010);
    end
    start_run(3, 3'b010, 1'b0);
    wait_done("three_pass");
    total++;
    if ({pass, busy} !== 2'b10 || err_count !== '0) begin
      bad++; $display("FAIL three_pass pass/busy=%b err=%0d want 10 err=0", {pass, busy}, err_count);
    end
    n_exp = exp_q.size();
    total++;
    if (n_issues - base != n_exp) begin
      bad++; $display("FAIL three_pass issue_count got=%0d want=%0d", n_issues - base, n_exp);
    end
    for (int k = base; k < n_issues; k++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL three_pass extra issue d1=%h", obs[k].d1);
      end else begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin bad++; $display("FAIL three_pass issue%0d got=%h want=%h", k - base, obs[k], e); end
      end
      if (k > base) begin
        total++;
        if (obs_cyc[k] - obs_cyc[k-1] != SPACING) begin
          bad++; $display("FAIL three_pass spacing got=%0d want=%0d", obs_cyc[k] - obs_cyc[k-1], SPACING);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_nan_mask();
    setvec(0, 32'hFFC0_0001, 5'h10, 32'h7FC0_0000, 5'h10);
    start_run(1, 3'd1, 1'b1);
    wait_done("nan_on");
    total++;
    if (pass !== 1'b1 || err_count !== '0) begin
      bad++; $display("FAIL nan_on pass=%b err=%0d want pass=1 err=0", pass, err_count);
    end
    start_run(1, 3'd1, 1'b0);
    wait_done("nan_off");
    total++;
    if (pass !== 1'b0 || err_count !== 16'd1 || fail_index !== '0) begin
      bad++; $display("FAIL nan_off pass=%b err=%0d idx=%0d want 0/1/0", pass, err_count, fail_index);
    end
    total++;
    if (fail_ref !== 32'hFFC0_0001 || fail_calc !== 32'h7FC0_0000 ||
        fail_flags_ref !== 5'h10 || fail_flags_calc !== 5'h10) begin
      bad++; $display("FAIL nan_off capture ref=%h calc=%h fr=%h fc=%h want ffc00001/7fc00000/10/10",
                      fail_ref, fail_calc, fail_flags_ref, fail_flags_calc);
    end
    // Exponent/quiet-bit disagreement is still a mismatch under masking.
    setvec(0, 32'h7F80_0000, 5'h00, 32'h7FC0_0000, 5'h00);
    start_run(1, 3'd1, 1'b1);
    wait_done("nan_exp");
    total++;
    if (pass !== 1'b0 || err_count !== 16'd1 || fail_ref !== 32'h7F80_0000) begin
      bad++; $display("FAIL nan_exp pass=%b err=%0d ref=%h want 0/1/7f800000", pass, err_count, fail_ref);
    end
  endtask

  task automatic test_flag_mismatch();
    int base = n_issues;
    int n_exp;
    issue_t e;
    logic [31:0] r2;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] r = $urandom();
      setvec(i, r, 5'h00, r, (i == 2) ? 5'h01 : 5'h00);
      if (i < FLAG_ISSUES) push_exp(i, 3'b100);
    end
    r2 = mem[2][95:64];
    start_run(4, 3'b100, 1'b0);
    wait_done("flag_mismatch");
    total++;
    if (pass !== 1'b0 || err_count !== 16'd1 || fail_index !== 16'd2) begin
      bad++; $display("FAIL flag_mismatch pass=%b err=%0d idx=%0d want 0/1/2", pass, err_count, fail_index);
    end
    total++;
    if (fail_flags_ref !== 5'h00 || fail_flags_calc !== 5'h01 || fail_ref !== r2 || fail_calc !== r2) begin
      bad++; $display("FAIL flag_capture fr=%h fc=%h ref=%h calc=%h want 00/01/%h/%h",
                      fail_flags_ref, fail_flags_calc, fail_ref, fail_calc, r2, r2);
    end
    n_exp = exp_q.size();
    total++;
    if (n_issues - base != n_exp) begin
      bad++; $display("FAIL flag_mismatch issue_count got=%0d want=%0d", n_issues - base, n_exp);
    end
    for (int k = base; k < n_issues; k++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL flag_mismatch extra issue d1=%h", obs[k].d1);
      end else begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin bad++; $display("FAIL flag_mismatch issue%0d got=%h want=%h", k - base, obs[k], e); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midrun();
    int base = n_issues;
    int n = 0;
    int n_exp;
    issue_t e;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] r = $urandom();
      setvec(i, r, 5'h02, r, 5'h02);
    end
    push_exp(0, 3'b001);
    push_exp(1, 3'b001);
    start_run(3, 3'b001, 1'b0);
    while (n_issues - base < 2 && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    total++;
    if (n_issues - base < 2) begin
      bad++; $display("FAIL reset_midrun timeout issues=%0d want 2", n_issues - base);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, fp_enable, vec_rd, done} !== 4'b0 || err_count !== '0) begin
      bad++; $display("FAIL reset_midrun busy/en/rd/done=%b err=%0d want 0000 err=0",
                      {busy, fp_enable, vec_rd, done}, err_count);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #1;
    n_exp = exp_q.size();
    total++;
    if (n_issues - base != n_exp) begin
      bad++; $display("FAIL reset_midrun issue_count got=%0d want=%0d", n_issues - base, n_exp);
    end
    for (int k = base; k < n_issues; k++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL reset_midrun extra issue d1=%h", obs[k].d1);
      end else begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin bad++; $display("FAIL reset_midrun issue%0d got=%h want=%h", k - base, obs[k], e); end
      end
    end
    exp_q.delete();
    // A rerun starts again at vector 0.
    base = n_issues;
    for (int i = 0; i < 3; i++) push_exp(i, 3'b101);
    start_run(3, 3'b101, 1'b0);
    wait_done("rerun");
    total++;
    if (pass !== 1'b1 || err_count !== '0) begin
      bad++; $display("FAIL rerun pass=%b err=%0d want 1/0", pass, err_count);
    end
    n_exp = exp_q.size();
    total++;
    if (n_issues - base != n_exp) begin
      bad++; $display("FAIL rerun issue_count got=%0d want=%0d", n_issues - base, n_exp);
    end
    for (int k = base; k < n_issues; k++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL rerun extra issue d1=%h", obs[k].d1);
      end else begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin bad++; $display("FAIL rerun issue%0d got=%h want=%h", k - base, obs[k], e); end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int base = n_issues;
    int n_exp;
    issue_t e;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] r = $urandom();
      setvec(i, r, 5'h04, r, 5'h04);
      push_exp(i, 3'b011);
    end
    start_run(3, 3'b011, 1'b0);
    repeat (3) @(negedge clock);
    start_run(1, 3'b111, 1'b1);
    wait_done("busy_start");
    total++;
    if (pass !== 1'b1 || err_count !== '0) begin
      bad++; $display("FAIL busy_start pass=%b err=%0d want 1/0", pass, err_count);
    end
    n_exp = exp_q.size();
    total++;
    if (n_issues - base != n_exp) begin
      bad++; $display("FAIL busy_start issue_count got=%0d want=%0d", n_issues - base, n_exp);
    end
    for (int k = base; k < n_issues; k++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL busy_start extra issue d1=%h", obs[k].d1);
      end else begin
        e = exp_q.pop_front();
        if (obs[k] !== e) begin bad++; $display("FAIL busy_start issue%0d got=%h want=%h", k - base, obs[k], e); end
      end
    end
    exp_q.delete();
    // Failing run, then a start from DONE must clear the error state.
    setvec(0, 32'h3F80_0000, 5'h00, 32'h3F80_0001, 5'h00);
    start_run(1, 3'd0, 1'b0);
    wait_done("fail_run");
    total++;
    if (pass !== 1'b0 || err_count !== 16'd1) begin
      bad++; $display("FAIL fail_run pass=%b err=%0d want 0/1", pass, err_count);
    end
    setvec(0, 32'h3F80_0000, 5'h00, 32'h3F80_0000, 5'h00);
    start_run(1, 3'd0, 1'b0);
    total++;
    if ({busy, done} !== 2'b10 || err_count !== '0 || fail_calc !== '0) begin
      bad++; $display("FAIL restart busy/done=%b err=%0d calc=%h want 10/0/0", {busy, done}, err_count, fail_calc);
    end
    wait_done("restart");
    total++;
    if (pass !== 1'b1 || err_count !== '0) begin
      bad++; $display("FAIL restart pass=%b err=%0d want 1/0", pass, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_zero_count();
    test_three_pass();
    test_nan_mask();
    test_flag_mismatch();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_vector_seq.md
Name: fp_vector_seq

Overview:
- Synthesizable test-vector sequencer that sits directly upstream of fp_unit's execute port and consumes its results.
- Fetches stored vectors from a synchronous vector memory and issues them one at a time to fp_unit.
- Waits the fp_unit result latency, then compares the result and flags against the stored reference.
- Reports pass/fail status and counts. Enables on-chip or emulator self-test of compare and convert operations without a simulator file reader.

Parameters:
ADDR_W, 16, vector memory address width and counter width
FP_LAT, 1, cycles from fp_enable to valid fp_result/fp_flags (≥1)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle
vec_count  in  ADDR_W  number of vectors in run; sampled on accepted start
cfg_rm  in  3  rounding mode driven on fp_rm for whole run; sampled on start
cfg_nan_chk  in  1  1 = canonical-NaN masking on (arith/i2f ops); 0 = exact compare (cmp/f2i); sampled on start
vec_rd  out  1  vector memory read strobe
vec_addr  out  ADDR_W  vector memory address
vec_data  in  101  {flags_ref[100:96], result_ref[95:64], data2[63:32], data1[31:0]}; valid 1 cycle after vec_rd
fp_enable  out  1  one-cycle issue strobe to fp_unit
fp_data1  out  32  operand A
fp_data2  out  32  operand B
fp_rm  out  3  rounding mode
fp_result  in  32  fp_unit result, valid FP_LAT cycles after fp_enable
fp_flags  in  5  fp_unit exception flags {NV,DZ,OF,UF,NX}
busy  out  1  run in progress
done  out  1  run finished; held until next start
pass  out  1  valid when done=1
err_count  out  ADDR_W  mismatches seen in current/last run
fail_index  out  ADDR_W  index of first mismatching vector
fail_ref  out  32  reference result of first mismatch
fail_calc  out  32  calculated result of first mismatch
fail_flags_ref  out  5  reference flags of first mismatch
fail_flags_calc  out  5  calculated flags of first mismatch

Behaviour:
- Reset: all outputs 0, FSM in IDLE, index 0. Reset asserted mid-run aborts immediately; memory and fp_unit strobes drop in the same cycle.
- FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT, CHECK, DONE.
- IDLE:
  - start=1 samples vec_count, cfg_rm and cfg_nan_chk; clears err_count, done, pass and the fail_* outputs; sets busy.
  - If sampled vec_count=0, go to DONE with pass=1. Otherwise go to FETCH.
- FETCH: vec_rd=1, vec_addr=index; go to LOAD.
- LOAD: latch vec_data into internal registers; go to ISSUE.
- ISSUE: drive fp_data1/fp_data2 from the latched vector; fp_enable=1 for exactly this cycle; load the wait counter with FP_LAT-1; go to WAIT.
- WAIT: decrement the counter; at 0 go to CHECK. With FP_LAT=1, WAIT lasts 1 cycle.
- Operand hold: fp_data1, fp_data2 and fp_rm hold their values from ISSUE until the next ISSUE.
- CHECK: sample fp_result and fp_flags, then evaluate mismatch:
  - If cfg_nan_chk=1 and fp_result=0x7FC00000, result mismatch = (ref[30:22] != calc[30:22]). Sign and payload are ignored.
  - Otherwise result mismatch = (ref != calc) over all 32 bits.
  - Flags mismatch = (flags_ref != fp_flags).
  - On any mismatch: err_count++ (saturates at all-ones). If err_count was 0 before the increment, capture fail_index and the fail_* outputs.
- CHECK exit:
  - Without FP_SEQ_CONTINUE_EN, a mismatch goes to DONE with pass=0.
  - Else, if index+1 = vec_count, go to DONE with pass=(err_count==0).
  - Else index++ and go to FETCH.
- Throughput: one vector per 4+FP_LAT cycles; single outstanding operation.
- DONE: busy=0, done=1. start=1 returns to IDLE processing in the same edge, i.e. a new run starts.
- start while busy=1 is ignored.
- vec_count=all-ones is legal; the index never wraps within a run.

Optional Feature:
FP_SEQ_CONTINUE_EN
- Defined: a mismatch does not stop the run. All vec_count vectors are checked, err_count totals the mismatches, and fail_* hold the first mismatch.
- Undefined: the run halts at the first mismatch with err_count=1.
- pass=(err_count==0) in both builds.

Test Plan:
- vec_count=0, start pulse -> DONE next cycle, pass=1, err_count=0, fp_enable never asserted.
- 3 vectors, fp_unit model FP_LAT=1 returning refs exactly -> exactly 3 fp_enable pulses spaced 5 cycles apart, done=1, pass=1.
- cfg_nan_chk=1, ref=0xFFC00001, calc=0x7FC00000, flags equal -> no mismatch, pass=1. Same vector with cfg_nan_chk=0 -> fail_index=0, fail_ref=0xFFC00001, fail_calc=0x7FC00000.
- Vector 2 of 4 returns flags 0x01 vs ref 0x00 -> without macro: done, pass=0, err_count=1, fail_index=2, only 3 issues. With FP_SEQ_CONTINUE_EN: 4 issues, err_count=1.
- Reset asserted during WAIT of vector 1 -> busy=0, fp_enable=0, err_count=0 asynchronously. A following start reruns from index 0.
- start pulsed while busy -> ignored, run completes unchanged. start while done=1 -> new run, err_count cleared.
